// File: rtl/i2c_master_test.sv
// Single-byte I2C register-write / current-pointer-read master.
// One bit slot is four quarters of CLK_DIV clocks: SCL is low in Q0-Q1 and
// high in Q2-Q3. SDA only moves at the start of a slot, and the line is
// sampled on the last clock of Q3. Reset aborts silently, with no STOP.
module i2c_master_test #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NACK, S_STOP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;     // clocks within the current quarter
  logic [1:0] qtr_q, qtr_d;     // quarter within the current slot
  logic [2:0] bit_q, bit_d;     // bit within the current byte
  logic [7:0] sh_q, sh_d;       // outgoing byte, MSB is the bit on the wire
  logic [7:0] rx_q, rx_d;       // incoming read byte
  logic [7:0] reg_q, reg_d;
  logic [7:0] wd_q, wd_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       oe_q, oe_d;
  logic       qend, slot_end;

  // Bus levels {scl, oe} for a given state, quarter and outgoing bit.
  function automatic logic [1:0] drive(state_e s, logic [1:0] q, logic b);
    logic [1:0] r;
    case (s)
      S_IDLE:                   r = 2'b10;
      S_START:                  r = {1'b1, q[1]};
      S_ADDR, S_REG, S_WDATA:   r = {q[1], ~b};
      S_STOP: begin
        case (q)
          2'd0:    r = 2'b01;
          2'd1:    r = 2'b11;
          default: r = 2'b10;
        endcase
      end
      default:                  r = {q[1], 1'b0};
    endcase
    return r;
  endfunction

  assign qend     = (div_q == DIV_LAST);
  assign slot_end = qend && (qtr_q == 2'd3);

  // Next-state: timing counters, slot sequencing, data shifting.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        state_d = S_START;
        div_d   = 8'd0;
        qtr_d   = 2'd0;
        bit_d   = 3'd0;
        sh_d    = {cmd_dev_addr, cmd_rw};
        reg_d   = cmd_reg_addr;
        wd_d    = cmd_wdata;
        rw_d    = cmd_rw;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      div_d = qend ? 8'd0 : div_q + 8'd1;
      if (qend) qtr_d = qtr_q + 2'd1;
      if (slot_end) begin
        case (state_q)
          S_START: begin
            state_d = S_ADDR;
            bit_d   = 3'd0;
          end
          S_ADDR, S_REG, S_WDATA: begin
            if (bit_q == 3'd7) begin
              bit_d = 3'd0;
              case (state_q)
                S_ADDR:  state_d = S_ADDR_ACK;
                S_REG:   state_d = S_REG_ACK;
                default: state_d = S_WDATA_ACK;
              endcase
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
          S_ADDR_ACK: begin
            bit_d = 3'd0;
            if (sda_i) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (rw_q) begin
              state_d = S_RDATA;
            end else begin
              state_d = S_REG;
              sh_d    = reg_q;
            end
          end
          S_REG_ACK: begin
            bit_d = 3'd0;
            if (sda_i) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              state_d = S_WDATA;
              sh_d    = wd_q;
            end
          end
          S_WDATA_ACK: begin
            if (sda_i) nack_d = 1'b1;
            state_d = S_STOP;
          end
          S_RDATA: begin
            rx_d = {rx_q[6:0], sda_i};
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = S_RDATA_NACK;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          S_RDATA_NACK: begin
            rdata_d = rx_q;
            state_d = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
    {scl_d, oe_d} = drive(state_d, qtr_d, sh_d[7]);
  end

  // State and registered bus outputs; reset also aborts a live transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      rx_q    <= 8'd0;
      reg_q   <= 8'd0;
      wd_q    <= 8'd0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign nack   = nack_q;
  assign rdata  = rdata_q;
  assign scl_o  = scl_q;
  assign sda_o  = 1'b0;
  assign sda_oe = oe_q;

endmodule

// File: tb/tb_i2c_master_test.sv
// Bench for i2c_master_test: behavioural register slave on a wired-AND SDA,
// a slot-list bus model checked every cycle, a bus-edge monitor, and
// literal latency/data expectations.
module tb_i2c_master_test;
  localparam int D = 8;
  localparam logic [6:0] SLV = 7'h50;
  localparam int SL_START = 0, SL_B0 = 1, SL_B1 = 2, SL_REL = 3, SL_STOP = 4;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, cmd_wdata;
  logic       busy, done, nack, scl_o, sda_o, sda_oe;
  logic [7:0] rdata;
  logic       sda_line;
  logic       slv_oe = 1'b0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_line = (sda_oe ? sda_o : 1'b1) & ~slv_oe;

  i2c_master_test #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .busy(busy), .done(done), .nack(nack),
    .rdata(rdata), .scl_o(scl_o), .sda_i(sda_line), .sda_o(sda_o),
    .sda_oe(sda_oe)
  );

  // Behavioural slave: register pointer + data write, current-pointer read.
  logic       s_scl_p = 1'b1, s_sda_p = 1'b1, sact = 1'b0;
  logic       match = 1'b0, srw = 1'b0, txing = 1'b0;
  logic [7:0] ssh = 8'd0, tx = 8'd0, ptr = 8'd0;
  logic [7:0] smem [256];
  int         k = 0, byten = 0;

  always @(negedge clk) begin
    if (rst) begin
      slv_oe <= 1'b0; sact <= 1'b0; txing <= 1'b0;
      s_scl_p <= 1'b1; s_sda_p <= 1'b1;
    end else begin
      s_scl_p <= scl_o;
      s_sda_p <= sda_line;
      if (s_scl_p && scl_o && s_sda_p && !sda_line) begin
        sact <= 1'b1; k <= 0; byten <= 0; txing <= 1'b0; match <= 1'b0; slv_oe <= 1'b0;
      end else if (s_scl_p && scl_o && !s_sda_p && sda_line) begin
        sact <= 1'b0; slv_oe <= 1'b0;
      end else if (sact && !s_scl_p && scl_o) begin
        if (k < 8) ssh <= {ssh[6:0], sda_line};
        k <= k + 1;
      end else if (sact && s_scl_p && !scl_o) begin
        if (k == 8) begin
          if (txing) slv_oe <= 1'b0;
          else if (byten == 0) begin
            match <= (ssh[7:1] == SLV); srw <= ssh[0]; slv_oe <= (ssh[7:1] == SLV);
          end else if (match) begin
            if (byten == 1) ptr <= ssh; else smem[ptr] <= ssh;
            slv_oe <= 1'b1;
          end
        end else if (k == 9) begin
          k <= 0; byten <= byten + 1; slv_oe <= 1'b0;
          if (match && srw && byten == 0) begin
            txing <= 1'b1; tx <= smem[ptr]; slv_oe <= ~smem[ptr][7];
          end else if (txing) txing <= 1'b0;
        end else if (txing && k >= 1 && k <= 7) begin
          slv_oe <= ~tx[3'(7 - k)];
        end
      end
    end
  end

  // Model state
  int         n_chk = 0, n_fail = 0;
  int         n_start = 0, n_stop = 0;
  int         slots[$];
  int         nd = 0, acc_cyc = 0;
  logic       mdl_on;
  logic       exp_nack = 1'b0;
  logic [7:0] exp_rdata = 8'd0, cur_rdata = 8'd0, mdl_ptr = 8'd0;
  logic [7:0] mdl_mem [256];

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  // {scl, sda_oe} required inside one slot
  function automatic logic [1:0] wave(int code, int q);
    case (code)
      SL_START: return {1'b1, q >= 2};
      SL_B0:    return {q >= 2, 1'b1};
      SL_B1:    return {q >= 2, 1'b0};
      SL_REL:   return {q >= 2, 1'b0};
      default:  return (q == 0) ? 2'b01 : (q == 1) ? 2'b11 : 2'b10;
    endcase
  endfunction

  task automatic build(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    logic [7:0] a;
    logic m;
    a = {dev, rw};
    m = (dev == SLV);
    slots.delete();
    slots.push_back(SL_START);
    for (int i = 7; i >= 0; i--) slots.push_back(a[i] ? SL_B1 : SL_B0);
    slots.push_back(SL_REL);
    if (m && rw) begin
      for (int i = 0; i < 9; i++) slots.push_back(SL_REL);
    end else if (m) begin
      for (int i = 7; i >= 0; i--) slots.push_back(ra[i] ? SL_B1 : SL_B0);
      slots.push_back(SL_REL);
      for (int i = 7; i >= 0; i--) slots.push_back(wd[i] ? SL_B1 : SL_B0);
      slots.push_back(SL_REL);
    end
    slots.push_back(SL_STOP);
    nd = slots.size() * 4 * D;
    exp_nack = !m;
    exp_rdata = (m && rw) ? mdl_mem[mdl_ptr] : cur_rdata;
  endtask

  task automatic compare_loop();
    int t, s, q;
    logic [1:0] w;
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        t = cyc - acc_cyc;
        if (t < nd) begin
          s = t / (4 * D);
          q = (t / D) % 4;
          w = wave(slots[s], q);
          chk("bus", t, 32'({busy, done, scl_o, sda_oe, sda_o}), 32'({2'b10, w, 1'b0}));
        end else if (t == nd) begin
          chk("end_bus", t, 32'({busy, done, scl_o, sda_oe, sda_o}), 32'h0C);
          chk("end_nack", t, 32'(nack), 32'(exp_nack));
          chk("end_rdata", t, 32'(rdata), 32'(exp_rdata));
        end else if (t == nd + 1) begin
          chk("post_bus", t, 32'({busy, done, scl_o, sda_oe, sda_o}), 32'h04);
        end
      end
    end
  endtask

  // SDA edges while SCL stays high: falling = START, rising = STOP.
  task automatic monitor_loop();
    logic ps, pd;
    ps = 1'b1; pd = 1'b1;
    forever begin
      @(posedge clk);
      if (!rst && ps && scl_o && pd != sda_line) begin
        if (!sda_line) n_start++; else n_stop++;
      end
      ps = scl_o; pd = sda_line;
    end
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input int lat, input int abort_at, input int poke_at);
    int n, s0, p0;
    logic seen;
    build(rw, dev, ra, wd);
    @(posedge clk); #1;
    cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc; mdl_on = 1'b1; s0 = n_start; p0 = n_stop;
    n = 0;
    while (!done && n < 3000) begin
      if (n == poke_at) begin
        cmd_valid = 1'b1; cmd_rw = ~rw; cmd_dev_addr = 7'h51; cmd_reg_addr = 8'hFF; cmd_wdata = ~wd;
      end else if (n == poke_at + 1) cmd_valid = 1'b0;
      if (n == abort_at - 1) begin rst = 1'b1; mdl_on = 1'b0; end
      @(posedge clk); #1;
      n++;
      if (n == abort_at) break;
    end
    if (abort_at > 0) begin
      chk("abort_scl", n, 32'(scl_o), 32'd1);
      chk("abort_oe", n, 32'(sda_oe), 32'd0);
      chk("abort_busy", n, 32'(busy), 32'd0);
      chk("abort_done", n, 32'(done), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      chk("abort_no_done", n, 32'(seen), 32'd0);
      chk("abort_start_edges", n, 32'(n_start - s0), 32'd1);
      chk("abort_stop_edges", n, 32'(n_stop - p0), 32'd0);
      cur_rdata = 8'd0;
    end else begin
      chk("latency", n, 32'(n), 32'(lat));
      repeat (2) @(posedge clk); #1;
      mdl_on = 1'b0;
      chk("start_edges", n, 32'(n_start - s0), 32'd1);
      chk("stop_edges", n, 32'(n_stop - p0), 32'd1);
      if (!exp_nack) begin
        if (rw) cur_rdata = exp_rdata;
        else begin mdl_ptr = ra; mdl_mem[ra] = wd; end
      end
    end
  endtask

  initial begin
    mdl_on = 1'b0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'd0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_dev_addr = 7'd0; cmd_reg_addr = 8'd0; cmd_wdata = 8'd0;
    fork
      compare_loop();
      monitor_loop();
    join_none
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk("rst_nack", 0, 32'(nack), 32'd0);
    chk("rst_rdata", 0, 32'(rdata), 32'd0);
    chk("rst_scl", 0, 32'(scl_o), 32'd1);
    chk("rst_sda_o", 0, 32'(sda_o), 32'd0);
    chk("rst_sda_oe", 0, 32'(sda_oe), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // write 0x50 reg2 <= A5
    run_cmd(1'b0, 7'h50, 8'h02, 8'hA5, 928, -1, -1);
    chk("wr_mem2", 0, 32'(smem[8'h02]), 32'hA5);
    chk("wr_nack", 0, 32'(nack), 32'd0);
    // read back
    run_cmd(1'b1, 7'h50, 8'h00, 8'h00, 640, -1, -1);
    chk("rd_rdata", 0, 32'(rdata), 32'hA5);
    chk("rd_nack", 0, 32'(nack), 32'd0);
    // wrong address write
    run_cmd(1'b0, 7'h51, 8'h02, 8'h5A, 352, -1, -1);
    chk("nk_nack", 0, 32'(nack), 32'd1);
    chk("nk_rdata", 0, 32'(rdata), 32'hA5);
    chk("nk_mem2", 0, 32'(smem[8'h02]), 32'hA5);
    // write with a stray command while busy
    run_cmd(1'b0, 7'h50, 8'h07, 8'h3C, 928, -1, 200);
    chk("poke_nack_clr", 0, 32'(nack), 32'd0);
    chk("poke_mem7", 0, 32'(smem[8'h07]), 32'h3C);
    run_cmd(1'b1, 7'h50, 8'h00, 8'h00, 640, -1, -1);
    chk("rd7_rdata", 0, 32'(rdata), 32'h3C);
    // wrong address read
    run_cmd(1'b1, 7'h51, 8'h00, 8'h00, 352, -1, -1);
    chk("rnk_nack", 0, 32'(nack), 32'd1);
    chk("rnk_rdata", 0, 32'(rdata), 32'h3C);
    // reset mid-write
    run_cmd(1'b0, 7'h50, 8'h09, 8'h77, 0, 300, -1);
    chk("abort_rdata", 0, 32'(rdata), 32'd0);
    // cmd_valid together with rst is dropped
    @(posedge clk); #1;
    rst = 1'b1; cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h50;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rstcmd_busy0", 0, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rstcmd_busy1", 0, 32'(busy), 32'd0);
    chk("rstcmd_scl", 0, 32'(scl_o), 32'd1);
    // recovery write
    run_cmd(1'b0, 7'h50, 8'h09, 8'h77, 928, -1, -1);
    chk("rec_nack", 0, 32'(nack), 32'd0);
    chk("rec_mem9", 0, 32'(smem[8'h09]), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
